regfile_dump: RTL
=================

REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, dump request, sampled only in IDLE.
REQ-006 SHALL have port first_addr, input, ADDRESS_WIDTH, first register of the range, latched on accepted start.
REQ-007 SHALL have port last_addr, input, ADDRESS_WIDTH, last register of the range (inclusive), latched on accepted start.
REQ-008 SHALL have port rd_addr, output, ADDRESS_WIDTH, drives a register-file read address port.
REQ-009 SHALL have port rd_data, input, DATA_WIDTH, combinational read data for rd_addr, same cycle.
REQ-010 SHALL have port out_valid, output, 1, beat valid.
REQ-011 SHALL have port out_ready, input, 1, sink ready.
REQ-012 SHALL have port out_data, output, DATA_WIDTH, captured register value.
REQ-013 SHALL have port out_addr, output, ADDRESS_WIDTH, register number of out_data.
REQ-014 SHALL have port out_last, output, 1, marks the final beat of a dump.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse at dump end.
REQ-017 SHALL have port range_err, output, 1, asserted with done when first_addr > last_addr.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD, SEND and FIN.
REQ-019 In IDLE with start=1, SHALL latch the range, load the address counter with first_addr and go to LOAD; if first_addr > last_addr, SHALL go to FIN with range_err set.
REQ-020 In LOAD, SHALL drive rd_addr = counter, register rd_data into out_data and the counter into out_addr, and go to SEND.
REQ-021 In SEND, SHALL hold out_valid=1 with out_data, out_addr and out_last stable until out_valid and out_ready are both high.
REQ-022 On a SEND handshake with counter == last_addr, SHALL go to FIN; otherwise SHALL increment the counter and go to LOAD.
REQ-023 In FIN, SHALL pulse done for exactly one cycle (with range_err if set) and return to IDLE; range_err SHALL clear in IDLE.
REQ-024 Latency: with start accepted at edge N and out_ready held high, SHALL present the first beat valid in the cycle after edge N+1 and a new beat every 2 cycles.
REQ-025 SHALL set out_last only on the beat whose out_addr equals last_addr.
REQ-026 Range end at 2**ADDRESS_WIDTH-1: SHALL terminate on the equality compare and SHALL never wrap the counter to 0.
REQ-027 SHALL ignore start while busy=1; the latched range SHALL be unaffected.
REQ-028 rd_addr SHALL hold the counter value in every state; its value outside LOAD is don't-care to the sink.

Reset
REQ-029 rst_n=0 SHALL force IDLE immediately, regardless of clock.
REQ-030 Reset SHALL clear out_valid, out_last, busy, done and range_err, and zero out_data, out_addr, counter and rd_addr.
REQ-031 Reset mid-dump SHALL abandon the dump with no done pulse.

Configuration
REQ-032 Macro REGFILE_DUMP_SKIP_ZERO_EN, when defined, SHALL make register 0 produce no beat: a counter of 0 in LOAD advances without capture; a range of exactly {0} yields no beats and only a done pulse.
REQ-033 Without REGFILE_DUMP_SKIP_ZERO_EN, register 0 SHALL be dumped like any other register.

Structure
REQ-034 The shared package regfile_pkg SHALL hold the default ADDRESS_WIDTH and DATA_WIDTH constants and the dump FSM state enum typedef.
REQ-035 The block SHALL be a single module with no sub-module.

Verification
REQ-036 Scenario: preload regs 3..5 with 0xA3, 0xA5, 0xA7, start first=3 last=5, out_ready=1 -> beats (3,0xA3), (4,0xA5), (5,0xA7,last); done 1 cycle after the last handshake.
REQ-037 Scenario: first=7 last=7, out_ready low 4 cycles -> single beat held stable, out_last=1, done after the handshake.
REQ-038 Scenario: first=9 last=2 -> no beats, done=1 and range_err=1 in the same cycle, busy low the next cycle.
REQ-039 Scenario: first=30 last=31 -> beats 30 and 31 only, no beat for address 0.
REQ-040 Scenario: start pulsed again mid-dump with first=0 -> ignored, original sequence intact; rst_n=0 during SEND -> out_valid and busy drop immediately, no done.
REQ-041 Scenario: with REGFILE_DUMP_SKIP_ZERO_EN, first=0 last=1 -> one beat, address 1 only.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and dump FSM state type for regfile_dump
package regfile_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 5;
    localparam int DEFAULT_DATA_WIDTH    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_FIN  = 2'd3
    } dump_state_e;

endpackage

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - streams a register-file address range out as valid/ready beats
// Optional: REGFILE_DUMP_SKIP_ZERO_EN suppresses the beat for register 0.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] first_addr,
    input  logic [ADDRESS_WIDTH-1:0] last_addr,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH-1:0] out_addr,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     range_err
);

    localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

    dump_state_e              state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] last_q, last_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic [ADDRESS_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                     out_last_q, out_last_d;
    logic                     range_err_q, range_err_d;

    logic at_end;
    logic skip_zero;

    assign at_end = (cnt_q == last_q);

`ifdef REGFILE_DUMP_SKIP_ZERO_EN
    assign skip_zero = (cnt_q == '0);
`else
    assign skip_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            range_err_q <= range_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = (first_addr > last_addr) ? ST_FIN : ST_LOAD;
            end
            ST_LOAD: begin
                if (skip_zero) state_d = at_end ? ST_FIN : ST_LOAD;
                else           state_d = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) state_d = at_end ? ST_FIN : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter only advances while below last_q, so it can never wrap past the top address.
    always_comb begin
        cnt_d       = cnt_q;
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        range_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d       = first_addr;
                    last_d      = last_addr;
                    range_err_d = (first_addr > last_addr);
                end
            end
            ST_LOAD: begin
                if (skip_zero) begin
                    if (!at_end) cnt_d = cnt_q + ONE;
                end else begin
                    out_data_d = rd_data;
                    out_addr_d = cnt_q;
                    out_last_d = at_end;
                end
            end
            ST_SEND: begin
                if (out_ready && !at_end) cnt_d = cnt_q + ONE;
            end
            default: begin
                range_err_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_SEND);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FIN);
        range_err = range_err_q;
        rd_addr   = cnt_q;
        out_data  = out_data_q;
        out_addr  = out_addr_q;
        out_last  = out_last_q;
    end

endmodule
